// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
// Holds the FSM state encoding, the Booth pair codes and the counter sizing.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // {Qx[0], q_m1} pairs that trigger an arithmetic action; 00 and 11 hold A.
  localparam logic [1:0] PAIR_SUB = 2'b10;
  localparam logic [1:0] PAIR_ADD = 2'b01;

  // The step counter must hold WIDTH+1 down to 0.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration on N-bit registers:
// conditional add/subtract of Mx into A, then arithmetic shift of {A,Qx,q_m1}.
module booth_step #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] qx,
  input  logic [N-1:0] mx,
  input  logic         q_m1,
  output logic [N-1:0] a_next,
  output logic [N-1:0] qx_next,
  output logic         q_m1_next
);
  import booth_pkg::*;

  logic [N-1:0] a_sum;

  always_comb begin
    a_sum = a;
    case ({qx[0], q_m1})
      PAIR_SUB: a_sum = a - mx;
      PAIR_ADD: a_sum = a + mx;
      default:  a_sum = a;
    endcase
  end

  assign a_next    = {a_sum[N-1], a_sum[N-1:1]};
  assign qx_next   = {a_sum[0], qx[N-1:1]};
  assign q_m1_next = qx[0];

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential Booth multiplier: one Booth step per clock on WIDTH+1-bit operands,
// so signed and unsigned products share the same datapath.
module booth_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  import booth_pkg::*;

  localparam int N  = WIDTH + 1;
  localparam int CW = cnt_width(WIDTH);

  state_t               state_reg, state_next;
  logic [N-1:0]         a_reg, qx_reg, mx_reg;
  logic                 q_m1_reg;
  logic [CW-1:0]        count_reg;
  logic [2*WIDTH-1:0]   product_reg;

  logic [N-1:0]         a_step, qx_step;
  logic                 q_m1_step;
  logic                 last_step;

  // The extra top bit lets unsigned operands be treated as non-negative signed.
  function automatic logic [N-1:0] ext(input logic [WIDTH-1:0] v, input logic s);
    return {s & v[WIDTH-1], v};
  endfunction

  booth_step #(.N(N)) u_step (
    .a         (a_reg),
    .qx        (qx_reg),
    .mx        (mx_reg),
    .q_m1      (q_m1_reg),
    .a_next    (a_step),
    .qx_next   (qx_step),
    .q_m1_next (q_m1_step)
  );

  assign last_step = (count_reg == CW'(1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      qx_reg      <= '0;
      mx_reg      <= '0;
      q_m1_reg    <= 1'b0;
      count_reg   <= '0;
      product_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= '0;
            qx_reg    <= ext(Q, is_signed);
            mx_reg    <= ext(M, is_signed);
            q_m1_reg  <= 1'b0;
            count_reg <= CW'(WIDTH + 1);
          end
        end
        RUN: begin
          a_reg     <= a_step;
          qx_reg    <= qx_step;
          q_m1_reg  <= q_m1_step;
          count_reg <= count_reg - CW'(1);
          // Only the final step publishes, so product never shows a partial sum.
          if (last_step) product_reg <= {a_step[WIDTH-2:0], qx_step};
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign product = product_reg;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench: three multiplier instances (WIDTH 4, 8, 16) run directed,
// reset and randomised back-to-back traffic against an integer reference model.
module tb_booth_mul_seq;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: got timeout, required event", name);
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_w
      localparam int W  = 4 << gi;
      localparam int NR = 2000;

      logic             n_rst = 1'b0;
      logic             start = 1'b0;
      logic             is_signed = 1'b0;
      logic [W-1:0]     m = '0;
      logic [W-1:0]     q = '0;
      logic             busy, done;
      logic [2*W-1:0]   product;

      logic [2*W-1:0]   exp_q[$];
      logic [2*W-1:0]   e;
      int               done_cnt = 0;
      int               last_done = -1;
      bit               b2b = 1'b0;
      bit               fin_w = 1'b0;

      booth_mul_seq #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .is_signed (is_signed),
        .M         (m),
        .Q         (q),
        .busy      (busy),
        .done      (done),
        .product   (product)
      );

      function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic s);
        longint x, y;
        logic [63:0] r;
        if (s) begin
          x = longint'($signed(a));
          y = longint'($signed(b));
        end else begin
          x = longint'(a);
          y = longint'(b);
        end
        r = 64'(x * y);
        return r[2*W-1:0];
      endfunction

      // Monitor: every done cycle consumes one expected product.
      always @(negedge clk) begin
        if (n_rst && done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done_w%0d: got product %0h, required no done", W, product);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("product_w%0d", W), product, e);
          end
          if (b2b && last_done >= 0) chk($sformatf("done_spacing_w%0d", W), cyc - last_done, W + 3);
          last_done = cyc;
        end
      end

      task automatic run_one(input logic [W-1:0] mm, input logic [W-1:0] qq, input logic s,
                             input logic [2*W-1:0] exp_p);
        int lat, bcnt;
        @(negedge clk);
        m = mm; q = qq; is_signed = s; start = 1'b1;
        exp_q.push_back(exp_p);
        @(negedge clk);
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (!done && lat < 4 * W) begin
          if (busy) bcnt++;
          @(negedge clk);
          lat++;
        end
        chk($sformatf("latency_w%0d", W), lat, W + 1);
        chk($sformatf("busy_cycles_w%0d", W), bcnt, W + 1);
        @(negedge clk);
        chk($sformatf("done_pulse_w%0d", W), done, 1'b0);
      endtask

      task automatic set_rand(input logic s);
        m = W'($urandom);
        q = W'($urandom);
        is_signed = s;
        exp_q.push_back(ref_mul(m, q, s));
      endtask

      initial begin
        logic [W-1:0] pat, mn, mx_v, m4, q4;
        logic [63:0]  tmp;
        int idle_bad, dc0, t;

        pat  = W'(32'hA5A5_A5A5);
        mn   = {1'b1, {(W-1){1'b0}}};
        mx_v = {1'b0, {(W-1){1'b1}}};
        m4   = W'(3) << (W - 2);
        q4   = W'(3) << (W - 3);

        repeat (2) @(negedge clk);
        chk($sformatf("reset_busy_w%0d", W), busy, 1'b0);
        chk($sformatf("reset_done_w%0d", W), done, 1'b0);
        chk($sformatf("reset_product_w%0d", W), product, '0);
        n_rst = 1'b1;
        idle_bad = 0;
        repeat (6) begin
          @(negedge clk);
          if (busy || done || product != '0) idle_bad++;
        end
        chk($sformatf("idle_after_reset_w%0d", W), idle_bad, 0);

        tmp = 64'd9 << (2 * W - 5);
        run_one(m4, q4, 1'b0, tmp[2*W-1:0]);
        tmp = 64'd0 - (64'd3 << (2 * W - 5));
        run_one(m4, q4, 1'b1, tmp[2*W-1:0]);
        tmp = ((64'd1 << W) - 64'd1) * ((64'd1 << W) - 64'd1);
        run_one('1, '1, 1'b0, tmp[2*W-1:0]);
        tmp = 64'd1 << (2 * W - 2);
        run_one(mn, mn, 1'b1, tmp[2*W-1:0]);
        tmp = 64'd0 - (((64'd1 << (W - 1)) - 64'd1) << (W - 1));
        run_one(mx_v, mn, 1'b1, tmp[2*W-1:0]);
        run_one('0, pat, 1'b0, '0);
        run_one('0, pat, 1'b1, '0);
        run_one(pat, '0, 1'b1, '0);

        // start and operand changes while RUN must be ignored
        dc0 = done_cnt;
        @(negedge clk);
        m = pat; q = W'(37); is_signed = 1'b0; start = 1'b1;
        exp_q.push_back(ref_mul(pat, W'(37), 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; m = '1; q = '1; is_signed = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (W + 6) @(negedge clk);
        chk($sformatf("midrun_done_count_w%0d", W), done_cnt - dc0, 1);
        chk($sformatf("midrun_queue_empty_w%0d", W), exp_q.size(), 0);

        // asynchronous reset at RUN cycle 4, then a clean 13 x 11
        @(negedge clk);
        m = W'(13); q = W'(11); is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk($sformatf("midrun_rst_busy_w%0d", W), busy, 1'b0);
        chk($sformatf("midrun_rst_done_w%0d", W), done, 1'b0);
        chk($sformatf("midrun_rst_product_w%0d", W), product, '0);
        @(negedge clk);
        n_rst = 1'b1;
        run_one(W'(13), W'(11), 1'b0, (2*W)'(16'h008F));

        // back-to-back random traffic, unsigned half then signed half
        b2b = 1'b1;
        last_done = -1;
        @(negedge clk);
        set_rand(1'b0);
        start = 1'b1;
        for (int i = 0; i < NR; i++) begin
          t = 0;
          @(negedge clk);
          while (!done && t < W + 10) begin
            @(negedge clk);
            t++;
          end
          if (!done) begin
            fail_now($sformatf("b2b_done_w%0d", W));
            break;
          end
          if (i < NR - 1) set_rand(i + 1 >= NR / 2);
          else start = 1'b0;
        end
        repeat (3) @(negedge clk);
        b2b = 1'b0;
        chk($sformatf("final_queue_empty_w%0d", W), exp_q.size(), 0);
        fin_w = 1'b1;
      end
    end
  endgenerate

  initial begin
    int k;
    k = 0;
    while (k < 150000 && !(g_w[0].fin_w && g_w[1].fin_w && g_w[2].fin_w)) begin
      @(posedge clk);
      k++;
    end
    if (!(g_w[0].fin_w && g_w[1].fin_w && g_w[2].fin_w)) fail_now("global_timeout");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
